reg_bank_mem_ctrl: RTL and testbench

//   Parametrised successor of the datapath register bank. Holds MAR, MDR, PC, MBR, SP, LV, CPP, TOS, OPC, H.

---
 rtl/reg_bank_pkg.sv | 35 +++
 rtl/mem_xact_fsm.sv | 121 ++++++++++++
 rtl/reg_bank_mem_ctrl.sv | 124 ++++++++++++
 tb/tb_reg_bank_mem_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared encodings for the datapath register bank and its memory-transaction FSM.
// Register indices double as bit positions in the C-bus load mask.
package reg_bank_pkg;

    localparam int REG_MAR = 0;
    localparam int REG_MDR = 1;
    localparam int REG_PC  = 2;
    localparam int REG_MBR = 3;
    localparam int REG_SP  = 4;
    localparam int REG_LV  = 5;
    localparam int REG_CPP = 6;
    localparam int REG_TOS = 7;
    localparam int REG_OPC = 8;

    localparam logic [3:0] BSEL_MDR   = 4'd0;
    localparam logic [3:0] BSEL_PC    = 4'd1;
    localparam logic [3:0] BSEL_MBR_S = 4'd2;
    localparam logic [3:0] BSEL_MBR_U = 4'd3;
    localparam logic [3:0] BSEL_SP    = 4'd4;
    localparam logic [3:0] BSEL_LV    = 4'd5;
    localparam logic [3:0] BSEL_CPP   = 4'd6;
    localparam logic [3:0] BSEL_TOS   = 4'd7;
    localparam logic [3:0] BSEL_OPC   = 4'd8;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;
    localparam logic [1:0] MEM_FETCH = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_FETCH = 2'd3;

endpackage

// File: rtl/mem_xact_fsm.sv
// Single-outstanding memory transaction engine: latches address/data on the command edge,
// holds mem_req until mem_ack or timeout, and emits register load strobes on completion.
module mem_xact_fsm
    import reg_bank_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        mem_op,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] mar_addr,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [DATA_W-1:0] mdr_val,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              err,
    output logic              mdr_ld,
    output logic              mbr_ld,
    output logic              pc_inc,
    output logic [1:0]        state_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              busy;
    logic              timeout_hit;

    assign busy        = (state_q != ST_IDLE);
    // The counter holds the number of ack-less cycles already spent, so the last one aborts.
    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        mdr_ld  = 1'b0;
        mbr_ld  = 1'b0;
        pc_inc  = 1'b0;
        if (!busy) begin
            if (mem_op != MEM_NONE) begin
                cnt_d = '0;
                case (mem_op)
                    MEM_READ: begin
                        state_d = ST_READ;
                        addr_d  = mar_addr;
                        we_d    = 1'b0;
                    end
                    MEM_WRITE: begin
                        state_d = ST_WRITE;
                        addr_d  = mar_addr;
                        wdata_d = mdr_val;
                        we_d    = 1'b1;
                    end
                    default: begin
                        state_d = ST_FETCH;
                        addr_d  = pc_addr;
                        we_d    = 1'b0;
                    end
                endcase
            end
        end else begin
            if (mem_op != MEM_NONE) begin
                err_d = 1'b1;
            end
            if (mem_ack) begin
                state_d = ST_IDLE;
                we_d    = 1'b0;
                mdr_ld  = (state_q == ST_READ);
                mbr_ld  = (state_q == ST_FETCH);
                pc_inc  = (state_q == ST_FETCH);
            end else if (timeout_hit) begin
                state_d = ST_IDLE;
                we_d    = 1'b0;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_req   = busy;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;
    assign state_o   = state_q;

endmodule

// File: rtl/reg_bank_mem_ctrl.sv
// Datapath register bank with B-bus source mux, masked C-bus loads and an attached
// memory-transaction FSM whose completions take priority over C-bus writes.
module reg_bank_mem_ctrl
    import reg_bank_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        bbus_sel,
    input  logic [8:0]        cbus_wr,
    input  logic              h_wr,
    input  logic [DATA_W-1:0] cbus_in,
    input  logic [1:0]        mem_op,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] bbus_out,
    output logic [DATA_W-1:0] h_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              err
);

    // MAR is only ever observed through the memory address, so only its low bits are kept.
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d, mdr_cb;
    logic [DATA_W-1:0] pc_q, pc_d, pc_cb;
    logic [7:0]        mbr_q, mbr_d;
    logic [DATA_W-1:0] sp_q, sp_d, lv_q, lv_d, cpp_q, cpp_d;
    logic [DATA_W-1:0] tos_q, tos_d, opc_q, opc_d, h_q, h_d;
    logic              mdr_ld, mbr_ld, pc_inc;
    logic [1:0]        fsm_state;

    always_comb begin
        mar_d  = cbus_wr[REG_MAR] ? cbus_in[ADDR_W-1:0] : mar_q;
        mdr_cb = cbus_wr[REG_MDR] ? cbus_in : mdr_q;
        pc_cb  = cbus_wr[REG_PC]  ? cbus_in : pc_q;
        mdr_d  = mdr_ld ? mem_rdata : mdr_cb;
        pc_d   = pc_inc ? pc_q + 1'b1 : pc_cb;
        mbr_d  = mbr_ld ? mem_rdata[7:0] : (cbus_wr[REG_MBR] ? cbus_in[7:0] : mbr_q);
        sp_d   = cbus_wr[REG_SP]  ? cbus_in : sp_q;
        lv_d   = cbus_wr[REG_LV]  ? cbus_in : lv_q;
        cpp_d  = cbus_wr[REG_CPP] ? cbus_in : cpp_q;
        tos_d  = cbus_wr[REG_TOS] ? cbus_in : tos_q;
        opc_d  = cbus_wr[REG_OPC] ? cbus_in : opc_q;
        h_d    = h_wr ? cbus_in : h_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mar_q <= '0;
            mdr_q <= '0;
            pc_q  <= '0;
            mbr_q <= '0;
            sp_q  <= '0;
            lv_q  <= '0;
            cpp_q <= '0;
            tos_q <= '0;
            opc_q <= '0;
            h_q   <= '0;
        end else begin
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            pc_q  <= pc_d;
            mbr_q <= mbr_d;
            sp_q  <= sp_d;
            lv_q  <= lv_d;
            cpp_q <= cpp_d;
            tos_q <= tos_d;
            opc_q <= opc_d;
            h_q   <= h_d;
        end
    end

    // Command-edge address/data come from the C-bus-updated values; no memory load can
    // coincide with a command because commands are only accepted while idle.
    mem_xact_fsm #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) u_fsm (
        .clock     (clock),
        .reset     (reset),
        .mem_op    (mem_op),
        .mem_ack   (mem_ack),
        .mar_addr  (mar_d),
        .pc_addr   (pc_cb[ADDR_W-1:0]),
        .mdr_val   (mdr_cb),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .err       (err),
        .mdr_ld    (mdr_ld),
        .mbr_ld    (mbr_ld),
        .pc_inc    (pc_inc),
        .state_o   (fsm_state)
    );

    assign busy = (fsm_state != ST_IDLE);

    always_comb begin
        case (bbus_sel)
            BSEL_MDR:   bbus_out = mdr_q;
            BSEL_PC:    bbus_out = pc_q;
            BSEL_MBR_S: bbus_out = {{(DATA_W-8){mbr_q[7]}}, mbr_q};
            BSEL_MBR_U: bbus_out = {{(DATA_W-8){1'b0}}, mbr_q};
            BSEL_SP:    bbus_out = sp_q;
            BSEL_LV:    bbus_out = lv_q;
            BSEL_CPP:   bbus_out = cpp_q;
            BSEL_TOS:   bbus_out = tos_q;
            BSEL_OPC:   bbus_out = opc_q;
            default:    bbus_out = '0;
        endcase
    end

    assign h_out = h_q;

endmodule

// File: tb/tb_reg_bank_mem_ctrl.sv
// Bench for reg_bank_mem_ctrl: directed scenarios plus random traffic against a
// transaction-level model of the register file and the single outstanding memory request.
module tb_reg_bank_mem_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int TO = 15;

    // ---------------- clock / reset ----------------
    logic          clock;
    logic          reset;
    logic [3:0]    bbus_sel;
    logic [8:0]    cbus_wr;
    logic          h_wr;
    logic [DW-1:0] cbus_in;
    logic [1:0]    mem_op;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] bbus_out;
    logic [DW-1:0] h_out;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          err;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    reg_bank_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .bbus_sel  (bbus_sel),
        .cbus_wr   (cbus_wr),
        .h_wr      (h_wr),
        .cbus_in   (cbus_in),
        .mem_op    (mem_op),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .bbus_out  (bbus_out),
        .h_out     (h_out),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .err       (err)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // m_reg index = C-bus mask bit: MAR MDR PC MBR SP LV CPP TOS OPC
    logic [DW-1:0] m_reg [0:8];
    logic [DW-1:0] m_h;
    logic          m_err;
    logic          p_busy;
    logic [1:0]    p_kind;
    int            p_age;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic [AW-1:0] exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_checks++;
        if (got !== want) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_reg[i] = '0;
        m_h = '0;
        m_err = 1'b0;
        p_busy = 1'b0;
        p_kind = 2'd0;
        p_age = 0;
        p_addr = '0;
        p_wdata = '0;
        exp_q.delete();
    endtask

    function automatic logic [DW-1:0] model_bbus(input logic [3:0] sel);
        logic [DW-1:0] mbr;
        mbr = m_reg[3];
        case (sel)
            4'd0: return m_reg[1];
            4'd1: return m_reg[2];
            4'd2: return (mbr >= 128) ? (32'hFFFF_FF00 | mbr) : mbr;
            4'd3: return mbr;
            4'd4, 4'd5, 4'd6, 4'd7, 4'd8: return m_reg[sel];
            default: return '0;
        endcase
    endfunction

    // One rising edge of the design, described as register-file and transaction rules.
    task automatic model_edge();
        logic [DW-1:0] nxt [0:8];
        for (int i = 0; i < 9; i++) nxt[i] = cbus_wr[i] ? cbus_in : m_reg[i];
        nxt[3] = nxt[3] & 32'hFF;
        if (h_wr) m_h = cbus_in;
        if (p_busy) begin
            if (mem_op != 2'd0) m_err = 1'b1;
            if (mem_ack) begin
                if (p_kind == 2'd1) nxt[1] = mem_rdata;
                if (p_kind == 2'd3) begin
                    nxt[3] = mem_rdata & 32'hFF;
                    nxt[2] = m_reg[2] + 1;
                end
                p_busy = 1'b0;
            end else begin
                p_age++;
                if (TO > 0 && p_age == TO) begin
                    p_busy = 1'b0;
                    m_err = 1'b1;
                end
            end
        end else if (mem_op != 2'd0) begin
            p_busy = 1'b1;
            p_kind = mem_op;
            p_age = 0;
            p_addr = (mem_op == 2'd3) ? nxt[2][AW-1:0] : nxt[0][AW-1:0];
            if (mem_op == 2'd2) p_wdata = nxt[1];
            exp_q.push_back(p_addr);
        end
        for (int i = 0; i < 9; i++) m_reg[i] = nxt[i];
    endtask

    task automatic check_outputs();
        check("bbus", bbus_out, model_bbus(bbus_sel));
        check("h_out", h_out, m_h);
        check("mem_req", DW'(mem_req), DW'(p_busy));
        check("mem_we", DW'(mem_we), DW'(p_busy && p_kind == 2'd2));
        check("mem_addr", DW'(mem_addr), DW'(p_addr));
        check("mem_wdata", mem_wdata, p_wdata);
        check("busy", DW'(busy), DW'(p_busy));
        check("err", DW'(err), DW'(m_err));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        cbus_wr = '0;
        h_wr = 1'b0;
        mem_op = 2'd0;
        mem_ack = 1'b0;
    endtask

    // Inputs are held from just after one edge to just after the next.
    task automatic step();
        logic prev_req;
        prev_req = mem_req;
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
        if (!prev_req && mem_req) begin
            if (exp_q.size() > 0) check("req_addr_sb", DW'(mem_addr), DW'(exp_q.pop_front()));
            else check("req_queue_len", DW'(exp_q.size()), 1);
        end
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_outputs();
    endtask

    // ---------------- stimulus ----------------
    logic [DW-1:0] rd;
    int busy_cycles;
    int ack_pct;

    initial begin
        reset = 1'b1;
        bbus_sel = '0;
        cbus_in = '0;
        mem_rdata = '0;
        set_idle();
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        check_outputs();
        reset = 1'b0;

        // Reset arriving mid-READ drops the request without a clock edge.
        mem_op = 2'd1;
        step();
        set_idle();
        check("rst_pre_req", DW'(mem_req), 1);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_async_req", DW'(mem_req), 0);
        check("rst_async_busy", DW'(busy), 0);
        check_outputs();
        @(posedge clock);
        #1;
        reset = 1'b0;
        mem_op = 2'd1;
        step();
        check("rst_then_read_req", DW'(mem_req), 1);
        set_idle();
        mem_ack = 1'b1;
        mem_rdata = $urandom;
        step();
        do_reset();

        // Read with MAR written on the command cycle.
        cbus_in = 32'd5;
        cbus_wr = 9'b0_0000_0001;
        mem_op = 2'd1;
        step();
        check("rd_addr", DW'(mem_addr), 5);
        check("rd_req", DW'(mem_req), 1);
        set_idle();
        step();
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        set_idle();
        bbus_sel = 4'd0;
        #1;
        check("rd_mdr", bbus_out, 32'hDEAD_BEEF);
        check("rd_done_busy", DW'(busy), 0);

        // Fetch from PC=3.
        cbus_in = 32'd3;
        cbus_wr = 9'b0_0000_0100;
        step();
        set_idle();
        mem_op = 2'd3;
        step();
        check("fe_addr", DW'(mem_addr), 3);
        set_idle();
        mem_ack = 1'b1;
        mem_rdata = 32'h0000_00F0;
        step();
        set_idle();
        bbus_sel = 4'd1;
        #1;
        check("fe_pc", bbus_out, 32'd4);
        bbus_sel = 4'd2;
        #1;
        check("fe_mbr_sext", bbus_out, 32'hFFFF_FFF0);
        bbus_sel = 4'd3;
        #1;
        check("fe_mbr_zext", bbus_out, 32'h0000_00F0);

        // Write, then a command while busy is dropped and flags err.
        cbus_in = 32'h12;
        cbus_wr = 9'b0_0000_0010;
        step();
        cbus_in = 32'd7;
        cbus_wr = 9'b0_0000_0001;
        mem_op = 2'd2;
        step();
        check("wr_we", DW'(mem_we), 1);
        check("wr_addr", DW'(mem_addr), 7);
        check("wr_wdata", mem_wdata, 32'h12);
        set_idle();
        mem_op = 2'd1;
        step();
        check("wr_drop_err", DW'(err), 1);
        check("wr_drop_we", DW'(mem_we), 1);
        set_idle();
        mem_ack = 1'b1;
        step();
        set_idle();
        step();
        check("wr_done_req", DW'(mem_req), 0);

        // Timeout: read without ack stays busy for exactly TO cycles.
        do_reset();
        cbus_in = 32'h55;
        cbus_wr = 9'b0_0000_0010;
        step();
        set_idle();
        mem_op = 2'd1;
        step();
        set_idle();
        busy_cycles = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            busy_cycles++;
            step();
        end
        check("to_busy_cycles", DW'(busy_cycles), TO);
        check("to_err", DW'(err), 1);
        check("to_req", DW'(mem_req), 0);
        bbus_sel = 4'd0;
        #1;
        check("to_mdr_kept", bbus_out, 32'h55);

        // Memory completion beats a same-edge C-bus write to MDR.
        do_reset();
        mem_op = 2'd1;
        step();
        set_idle();
        rd = $urandom;
        mem_ack = 1'b1;
        mem_rdata = rd;
        cbus_wr = 9'b0_0000_0010;
        cbus_in = 32'hAA;
        step();
        set_idle();
        bbus_sel = 4'd0;
        #1;
        check("coll_mdr", bbus_out, rd);
        h_wr = 1'b1;
        cbus_in = 32'd9;
        step();
        set_idle();
        check("h_load", h_out, 32'd9);

        // Random traffic.
        ack_pct = 30;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc % 200 == 199) do_reset();
            if (cyc % 40 == 0) begin
                case ($urandom_range(0, 2))
                    0: ack_pct = 0;
                    1: ack_pct = 25;
                    default: ack_pct = 70;
                endcase
            end
            bbus_sel  = 4'($urandom_range(0, 15));
            cbus_wr   = 9'($urandom & $urandom);
            h_wr      = ($urandom_range(0, 3) == 0);
            cbus_in   = $urandom;
            mem_op    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            mem_ack   = ($urandom_range(0, 99) < ack_pct);
            mem_rdata = $urandom;
            step();
        end
        set_idle();
        check("req_queue_end", DW'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
